// File: rtl/dmem_line_ctrl.sv
// Sole master of the data memory: write-through stores and critical-word-first line refills.
// Latency: write done 2 cycles after request edge, 4-word fill done 5 cycles after; each memory stall adds one cycle.
// Backpressure: Valid=0 holds the current word (address and index frozen); TIMEOUT consecutive stalls abort with err.
module dmem_line_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_read,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_idx,
    output logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             HSEL,
    output logic             re,
    output logic             we,
    output logic [31:0]      a,
    output logic [31:0]      wd,
    input  logic [31:0]      rd,
    input  logic             Valid
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:2]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               tmo_hit;
    logic               last_word;
    logic               addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[1:0];
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
    assign last_word = (cnt_q == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_write)     state_d = WRITE;
                else if (req_read) state_d = FILL;
            end
            WRITE: begin
                if (Valid || tmo_hit) state_d = DONE;
            end
            FILL: begin
                if ((Valid && last_word) || (!Valid && tmo_hit)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                tmo_d = '0;
                if (req_write) begin
                    addr_d  = req_addr[31:2];
                    wdata_d = req_wdata;
                end else if (req_read) begin
                    addr_d = req_addr[31:2];
                    idx_d  = req_addr[IDX_W+1:2];
                    cnt_d  = '0;
                end
            end
            WRITE, FILL: begin
                if (Valid) begin
                    tmo_d = '0;
                    if (state_q == FILL) begin
                        // index width equals log2(LINE_WORDS), so overflow is the wrap
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_hit) err_d = 1'b1;
                end
            end
            default: tmo_d = '0;
        endcase
    end

    always_comb begin
        fill_we   = 1'b0;
        fill_idx  = idx_q;
        fill_data = '0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        HSEL      = 1'b0;
        re        = 1'b0;
        we        = 1'b0;
        a         = '0;
        wd        = '0;
        case (state_q)
            WRITE: begin
                HSEL = 1'b1;
                we   = 1'b1;
                a    = {addr_q, 2'b00};
                wd   = wdata_q;
            end
            FILL: begin
                HSEL      = 1'b1;
                re        = 1'b1;
                a         = {addr_q[31:IDX_W+2], idx_q, 2'b00};
                fill_we   = Valid;
                fill_data = Valid ? rd : '0;
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Randomized bench: per-transaction expected traces built from the transfer rules, compared every cycle.
module tb_dmem_line_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        fill_we, busy, done, err, HSEL, re, we;
    logic [1:0]  fill_idx;
    logic [31:0] fill_data, a, wd, rd;
    logic        Valid = 1'b0;

    always #5 clk = ~clk;

    dmem_line_ctrl #(.LINE_WORDS(4), .IDX_W(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .fill_we(fill_we), .fill_idx(fill_idx),
        .fill_data(fill_data), .busy(busy), .done(done), .err(err), .HSEL(HSEL), .re(re),
        .we(we), .a(a), .wd(wd), .rd(rd), .Valid(Valid)
    );

    logic [31:0] dmem [0:255];
    logic [31:0] mmem [0:255];
    assign rd = dmem[a[9:2]];

    typedef struct {
        int          cyc;
        bit          busy, hsel, re, we, fwe, done, err;
        logic [31:0] a, wd, fdata;
        logic [1:0]  fidx;
    } exp_t;

    exp_t        eq[$];
    bit          vq[$], wq[$], rq[$];
    int          nvec = 0, nmis = 0;
    int          done_cyc, fill_cnt, hsel_cnt;
    bit          obs_err;
    logic [31:0] obs_a[$];
    logic [1:0]  obs_idx[$];
    logic [31:0] obs_fill [0:3];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic bit pick_valid(int mode, int words, int stall);
        case (mode)
            0:       return 1'b1;
            1:       return $urandom_range(0, 9) < 7;
            2:       return 1'b0;
            3:       return !(words == 1 && stall < 3);
            4:       return words < 2;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void push(exp_t e, bit v, bit w, bit r);
        e.cyc = eq.size();
        eq.push_back(e);
        vq.push_back(v);
        wq.push_back(w);
        rq.push_back(r);
    endfunction

    function automatic exp_t idle_rec();
        exp_t e;
        e = '{cyc: 0, busy: 0, hsel: 0, re: 0, we: 0, fwe: 0, done: 0, err: 0,
              a: '0, wd: '0, fdata: '0, fidx: '0};
        return e;
    endfunction

    // One transfer phase: a word (write) or a line (fill), then the DONE cycle.
    function automatic void add_phase(bit is_wr, logic [31:0] addr, logic [31:0] wdata,
                                      int mode, bit w, bit r);
        int         nw = is_wr ? 1 : 4;
        int         k = 0, t = 0;
        int         s = int'(addr[3:2]);
        bit         v;
        exp_t       e;
        logic [1:0] ix;
        while (k < nw && t < TMO) begin
            v = pick_valid(mode, k, t);
            e = idle_rec();
            e.busy = 1; e.hsel = 1;
            if (is_wr) begin
                e.we = 1; e.a = {addr[31:2], 2'b00}; e.wd = wdata;
            end else begin
                ix = 2'(s + k);
                e.re = 1; e.a = {addr[31:4], ix, 2'b00};
                e.fwe = v; e.fidx = ix; e.fdata = mmem[e.a[9:2]];
            end
            push(e, v, w, r);
            if (v) begin
                k++; t = 0;
                if (is_wr) mmem[addr[9:2]] = wdata;
            end else begin
                t++;
            end
        end
        e = idle_rec();
        e.busy = 1; e.done = 1; e.err = (k < nw);
        push(e, 1'($urandom_range(0, 1)), w, r);
    endfunction

    task automatic run_txn(bit do_wr, bit do_rd, logic [31:0] addr, logic [31:0] wdata, int mode);
        @(posedge clk); #1;
        eq.delete(); vq.delete(); wq.delete(); rq.delete();
        push(idle_rec(), 1'($urandom_range(0, 1)), do_wr, do_rd);
        if (do_wr) add_phase(1'b1, addr, wdata, mode, 1'b1, do_rd);
        if (do_wr && do_rd) push(idle_rec(), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        if (do_rd) add_phase(1'b0, addr, 32'h0, mode, 1'b0, 1'b1);
        push(idle_rec(), 1'b0, 1'b0, 1'b0);
        req_addr = addr; req_wdata = wdata;
        Valid = vq.pop_front(); req_write = wq.pop_front(); req_read = rq.pop_front();
        while (vq.size() > 0) begin
            @(posedge clk); #1;
            Valid = vq.pop_front(); req_write = wq.pop_front(); req_read = rq.pop_front();
        end
        @(negedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i] = $urandom;
            mmem[i] = dmem[i];
        end
        for (int i = 0; i < 4; i++) begin
            dmem[8'h80 + i] = 32'hA0 + i;
            mmem[8'h80 + i] = 32'hA0 + i;
        end

        fork
            forever begin
                @(posedge clk);
                if (HSEL && we && Valid) dmem[a[9:2]] <= wd;
            end
            forever begin : compare
                exp_t e;
                @(negedge clk);
                if (eq.size() > 0) begin
                    e = eq.pop_front();
                    if (e.cyc == 0) begin
                        done_cyc = -1; obs_err = 0; fill_cnt = 0; hsel_cnt = 0;
                        obs_a.delete(); obs_idx.delete();
                    end
                    chk("busy", 32'(busy), 32'(e.busy));
                    chk("HSEL", 32'(HSEL), 32'(e.hsel));
                    chk("re", 32'(re), 32'(e.re));
                    chk("we", 32'(we), 32'(e.we));
                    chk("fill_we", 32'(fill_we), 32'(e.fwe));
                    chk("done", 32'(done), 32'(e.done));
                    chk("err", 32'(err), 32'(e.err));
                    if (e.hsel) chk("a", a, e.a);
                    if (e.we) chk("wd", wd, e.wd);
                    if (e.fwe) begin
                        chk("fill_idx", 32'(fill_idx), 32'(e.fidx));
                        chk("fill_data", fill_data, e.fdata);
                    end
                    if (done) begin done_cyc = e.cyc; obs_err = err; end
                    if (HSEL && we) hsel_cnt++;
                    if (fill_we) begin
                        fill_cnt++;
                        obs_fill[fill_idx] = fill_data;
                        obs_idx.push_back(fill_idx);
                        obs_a.push_back(a);
                    end
                end
            end
        join_none

        #12;
        chk("rst_busy", 32'(busy), 0);  chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);    chk("rst_HSEL", 32'(HSEL), 0);
        chk("rst_re", 32'(re), 0);      chk("rst_we", 32'(we), 0);
        chk("rst_fill_we", 32'(fill_we), 0);
        chk("rst_fill_idx", 32'(fill_idx), 0);
        chk("rst_a", a, 0);             chk("rst_wd", wd, 0);
        @(posedge clk); #1 reset = 1'b0;

        run_txn(1'b1, 1'b0, 32'h104, 32'hDEAD_BEEF, 0);
        chk("wr_done_cyc", done_cyc, 2);
        chk("wr_hsel_cycles", hsel_cnt, 1);
        chk("wr_err", 32'(obs_err), 0);
        run_txn(1'b0, 1'b1, 32'h100, 32'h0, 0);
        chk("rd_word41", obs_fill[1], 32'hDEAD_BEEF);

        run_txn(1'b0, 1'b1, 32'h200, 32'h0, 0);
        chk("fill_done_cyc", done_cyc, 5);
        for (int i = 0; i < 4; i++) chk("fill_word", obs_fill[i], 32'hA0 + i);

        run_txn(1'b0, 1'b1, 32'h20C, 32'h0, 0);
        chk("wrap_a0", obs_a[0], 32'h20C); chk("wrap_a1", obs_a[1], 32'h200);
        chk("wrap_a2", obs_a[2], 32'h204); chk("wrap_a3", obs_a[3], 32'h208);
        chk("wrap_i0", 32'(obs_idx[0]), 3); chk("wrap_i1", 32'(obs_idx[1]), 0);

        run_txn(1'b0, 1'b1, 32'h200, 32'h0, 3);
        chk("stall_words", fill_cnt, 4);
        chk("stall_done_cyc", done_cyc, 8);

        run_txn(1'b0, 1'b1, 32'h240, 32'h0, 2);
        chk("tmo_done_cyc", done_cyc, 9);
        chk("tmo_err", 32'(obs_err), 1);
        run_txn(1'b0, 1'b1, 32'h248, 32'h0, 4);
        chk("tmo_partial_words", fill_cnt, 2);
        chk("tmo_partial_cyc", done_cyc, 11);

        run_txn(1'b1, 1'b1, 32'h108, 32'h1234_5678, 0);
        chk("prio_done_cyc", done_cyc, 8);
        chk("prio_fill_word", obs_fill[2], 32'h1234_5678);

        @(posedge clk); #1;
        req_read = 1'b1; req_addr = 32'h300; Valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 reset = 1'b1;
        #1;
        chk("arst_HSEL", 32'(HSEL), 0); chk("arst_re", 32'(re), 0);
        chk("arst_busy", 32'(busy), 0); chk("arst_done", 32'(done), 0);
        @(posedge clk); #1 req_read = 1'b0; Valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("arst_no_done", 32'(done), 0);
        end
        @(posedge clk); #1 reset = 1'b0;
        run_txn(1'b0, 1'b1, 32'h304, 32'h0, 0);
        chk("post_rst_done_cyc", done_cyc, 5);
        chk("post_rst_words", fill_cnt, 4);

        for (int n = 0; n < 60; n++) begin
            int op, mode;
            op = $urandom_range(0, 2);
            mode = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 2 : 4)
                                               : (($urandom_range(0, 3) == 0) ? 3 : 1);
            run_txn(op != 1, op != 0, 32'($urandom_range(0, 1023)), $urandom, mode);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
